// File: rtl/alu_control_mdu_pkg.sv
// Shared opcode, funct and ALU-code constants for the EX-stage ALU control and M-group unit.
// No logic here; consumed by the decoder, the MDU control and the iterative datapath.
// Backpressure: n/a.
package alu_control_mdu_pkg;

  // ALU operation codes; 0 doubles as "unknown encoding"
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_BEQ  = 4'd8;
  localparam logic [3:0] ALU_BNE  = 4'd9;
  localparam logic [3:0] ALU_BLT  = 4'd10;
  localparam logic [3:0] ALU_BGE  = 4'd11;

  // major opcodes
  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // funct3 for integer arithmetic
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL     = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  // funct3 for branches and the system group
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_PRIV = 3'b000;

  // funct7 selectors
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // M-group funct3
  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  // operation context latched at launch for result post-processing
  typedef struct packed {
    logic [2:0] funct3;
    logic       a_neg;    // operand A was negative (remainder sign)
    logic       res_neg;  // product / quotient must be negated
  } mdu_op_t;

  // operand A is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
  endfunction

  // operand B is treated as signed for MULH, DIV, REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/alu_control_mdu_iter_core.sv
// Iterative unsigned datapath: shift-add multiplier / restoring divider sharing one 2*XLEN accumulator.
// Latency: one bit per 'run' cycle, XLEN steps after 'start'; 'last' flags the final step.
// Backpressure: none; the controller gates 'run' and simply stops stepping on abort.
module mdu_iter_core
  import alu_control_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              last,
  output logic [2*XLEN-1:0] acc_next
);

  localparam int CW = $clog2(XLEN);

  // acc = {product_hi, multiplier} when multiplying, {remainder, quotient} when dividing
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     count;
  logic              div_mode;

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_trial;
  logic [XLEN:0] div_diff;
  logic          div_ge;

  assign last = (count == '0);

  // next accumulator value for one multiply or divide step
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_trial = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opnd};
    div_ge    = (div_trial >= {1'b0, opnd});
    if (div_mode) begin
      if (div_ge) acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else        acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // operand load on start, then one step per run cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      opnd     <= '0;
      count    <= '0;
      div_mode <= 1'b0;
    end else if (start) begin
      acc      <= {{XLEN{1'b0}}, op_a};
      opnd     <= op_b;
      count    <= CW'(XLEN-1);
      div_mode <= is_div;
    end else if (run) begin
      acc <= acc_next;
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control with RV32M/RV64M multiply/divide: decodes ALU codes, runs MUL/DIV iteratively.
// Latency: alu_op combinational; MUL/DIV result XLEN+1 cycles after launch (1 for div-by-zero/overflow).
// Backpressure: stall holds IF/ID/EX while an M op iterates; drops in the cycle out_valid pulses.
module alu_control_mdu
  import alu_control_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [1:0]      alu_op_sel,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [3:0]      alu_op,
  output logic            is_mdu,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] mdu_result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t  state;
  mdu_op_t op_q;
  logic    done_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign funct7        = instruction[31:25];
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  assign is_mdu = (ENABLE_M != 0) && (alu_op_sel == 2'b10) &&
                  (opcode == OPC_ARITH) && (funct7 == FUNCT7_MULDIV);

  // ALU code decode; M-group ops drive ADD and the ALU result is ignored
  always_comb begin
    alu_op = ALU_NONE;
    case (alu_op_sel)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      default: begin
        if (is_mdu) begin
          alu_op = ALU_ADD;
        end else begin
          case (opcode)
            OPC_ARITH, OPC_ARITH_IMM: begin
              case (funct3)
                FUNCT3_ADD_SUB: alu_op = (opcode == OPC_ARITH && funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
                FUNCT3_SLL:     alu_op = ALU_SLL;
                FUNCT3_XOR:     alu_op = ALU_XOR;
                FUNCT3_SRL:     alu_op = ALU_SRL;
                FUNCT3_OR:      alu_op = ALU_OR;
                FUNCT3_AND:     alu_op = ALU_AND;
                default:        alu_op = ALU_NONE;
              endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: alu_op = ALU_ADD;
            OPC_BRANCH: begin
              case (funct3)
                FUNCT3_BEQ: alu_op = ALU_BEQ;
                FUNCT3_BNE: alu_op = ALU_BNE;
                FUNCT3_BLT: alu_op = ALU_BLT;
                FUNCT3_BGE: alu_op = ALU_BGE;
                default:    alu_op = ALU_NONE;
              endcase
            end
            OPC_SYSTEM: alu_op = (funct3 == FUNCT3_PRIV) ? ALU_BEQ : ALU_NONE;
            default:    alu_op = ALU_NONE;
          endcase
        end
      end
    endcase
  end

  // launch qualification and operand magnitude / sign pre-processing
  logic            launch;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign launch   = (state == S_IDLE) && in_valid && is_mdu && !flush;
  assign a_neg    = a_is_signed(funct3) && rs1_data[XLEN-1];
  assign b_neg    = b_is_signed(funct3) && rs2_data[XLEN-1];
  assign a_mag    = a_neg ? -rs1_data : rs1_data;
  assign b_mag    = b_neg ? -rs2_data : rs2_data;
  assign div_zero = funct3[2] && (rs2_data == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
  assign special  = div_zero || div_ovf;

  // shortcut results: x/0 gives all ones or A, MIN/-1 gives A or 0
  always_comb begin
    if (div_zero) special_res = funct3[1] ? rs1_data : '1;
    else          special_res = funct3[1] ? '0 : rs1_data;
  end

  logic              core_run;
  logic              core_last;
  logic [2*XLEN-1:0] core_next;

  assign core_run = ((state == S_MUL) || (state == S_DIV)) && !flush;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (launch),
    .run      (core_run),
    .is_div   (funct3[2]),
    .op_a     (a_mag),
    .op_b     (b_mag),
    .last     (core_last),
    .acc_next (core_next)
  );

  // sign post-processing of the final step and result selection by funct3
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod_fix = op_q.res_neg ? -core_next : core_next;
    quo_fix  = op_q.res_neg ? -core_next[XLEN-1:0] : core_next[XLEN-1:0];
    rem_fix  = op_q.a_neg ? -core_next[2*XLEN-1:XLEN] : core_next[2*XLEN-1:XLEN];
    case (op_q.funct3)
      FUNCT3_MUL:                              final_res = prod_fix[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                 final_res = quo_fix;
      default:                                 final_res = rem_fix;
    endcase
  end

  assign stall     = launch || (state == S_MUL) || (state == S_DIV);
  assign out_valid = done_q && !flush;

  // MDU sequencing: launch, iterate, one-cycle DONE; flush aborts from any state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      done_q     <= 1'b0;
      mdu_result <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            op_q.funct3  <= funct3;
            op_q.a_neg   <= a_neg;
            op_q.res_neg <= a_neg ^ b_neg;
            if (special) begin
              mdu_result <= special_res;
              done_q     <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= funct3[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (core_last) begin
            mdu_result <= final_res;
            done_q     <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Randomised and directed bench for alu_control_mdu (XLEN=32) against a plain-arithmetic model.
// Checks decode, MUL/DIV results and stall latency, special cases, flush and reset aborts.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_alu_control_mdu;
  import alu_control_mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            flush;
  logic [1:0]      alu_op_sel;
  logic [31:0]     instruction;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [3:0]      alu_op;
  logic            is_mdu;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] mdu_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] last_res;

  alu_control_mdu #(.XLEN(XLEN), .ENABLE_M(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .flush       (flush),
    .alu_op_sel  (alu_op_sel),
    .instruction (instruction),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_op      (alu_op),
    .is_mdu      (is_mdu),
    .stall       (stall),
    .out_valid   (out_valid),
    .mdu_result  (mdu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    logic [4:0] r1, r2, rd;
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    rd = 5'($urandom);
    return {f7, r2, r1, f3, rd, opc};
  endfunction

  // reference M-extension semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_stalls(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 >= 3'd4 && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // run one M op to completion; checks decode, stall count, result
  task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int   stalls;
    bit   seen;
    logic st_done;
    logic [31:0] got;
    logic [31:0] exp_r;
    exp_r   = ref_mdu(f3, a, b);
    stalls  = 0;
    seen    = 1'b0;
    st_done = 1'b1;
    got     = '0;
    @(posedge clk); #1;
    in_valid    = 1'b1;
    alu_op_sel  = 2'b10;
    instruction = mk(FUNCT7_MULDIV, f3, OPC_ARITH);
    rs1_data    = a;
    rs2_data    = b;
    @(negedge clk);
    check_eq({tag, "_aluop"}, 64'(alu_op), 64'(ALU_ADD));
    check_eq({tag, "_ismdu"}, 64'(is_mdu), 64'd1);
    for (int c = 0; c < 200; c++) begin
      if (out_valid) begin
        seen    = 1'b1;
        got     = mdu_result;
        st_done = stall;
        break;
      end
      if (stall) stalls++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_valid"}, 64'(seen), 64'd1);
    check_eq({tag, "_stalls"}, 64'(stalls), 64'(ref_stalls(f3, a, b)));
    check_eq({tag, "_stall_done"}, 64'(st_done), 64'd0);
    check_eq({tag, "_res"}, 64'(got), 64'(exp_r));
    last_res = exp_r;
  endtask

  task automatic dec_check(input string tag, input logic [1:0] sel, input logic [31:0] ins, input logic [3:0] exp);
    @(posedge clk); #1;
    in_valid    = 1'b1;
    alu_op_sel  = sel;
    instruction = ins;
    rs1_data    = $urandom;
    rs2_data    = $urandom;
    @(negedge clk);
    check_eq(tag, 64'(alu_op), 64'(exp));
    check_eq({tag, "_stall"}, 64'(stall), 64'd0);
    check_eq({tag, "_ov"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int ov_cnt;
    reset       = 1'b1;
    in_valid    = 1'b0;
    flush       = 1'b0;
    alu_op_sel  = 2'b10;
    instruction = 32'h0000_0013;
    rs1_data    = '0;
    rs2_data    = '0;
    last_res    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_ov", 64'(out_valid), 64'd0);
    check_eq("rst_res", 64'(mdu_result), 64'd0);
    reset = 1'b0;

    // directed M-group cases
    run_mdu("mul",    FUNCT3_MUL,   32'hFFFF_FFFE, 32'd3);
    run_mdu("mulh",   FUNCT3_MULH,  32'hFFFF_FFFE, 32'd3);
    run_mdu("mulhu",  FUNCT3_MULHU, 32'hFFFF_FFFE, 32'd3);
    run_mdu("div",    FUNCT3_DIV,   32'hFFFF_FFF9, 32'd2);
    run_mdu("rem",    FUNCT3_REM,   32'hFFFF_FFF9, 32'd2);
    run_mdu("divu",   FUNCT3_DIVU,  32'hFFFF_FFF9, 32'd2);
    run_mdu("div0",   FUNCT3_DIV,   32'd5, 32'd0);
    run_mdu("remu0",  FUNCT3_REMU,  32'd5, 32'd0);
    run_mdu("ovfrem", FUNCT3_REM,   32'h8000_0000, 32'hFFFF_FFFF);
    run_mdu("ovfdiv", FUNCT3_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

    // non-M decode; result register must hold
    dec_check("add",   2'b10, mk(7'h00, 3'b000, OPC_ARITH), ALU_ADD);
    check_eq("hold", 64'(mdu_result), 64'(last_res));
    dec_check("sub",   2'b10, mk(FUNCT7_ALT, 3'b000, OPC_ARITH), ALU_SUB);
    dec_check("sll",   2'b10, mk(7'h00, 3'b001, OPC_ARITH), ALU_SLL);
    dec_check("srl",   2'b10, mk(7'h00, 3'b101, OPC_ARITH), ALU_SRL);
    dec_check("and",   2'b10, mk(7'h00, 3'b111, OPC_ARITH), ALU_AND);
    dec_check("or",    2'b10, mk(7'h00, 3'b110, OPC_ARITH), ALU_OR);
    dec_check("xor",   2'b10, mk(7'h00, 3'b100, OPC_ARITH), ALU_XOR);
    dec_check("slt",   2'b10, mk(7'h00, 3'b010, OPC_ARITH), ALU_NONE);
    dec_check("addi",  2'b10, mk(FUNCT7_ALT, 3'b000, OPC_ARITH_IMM), ALU_ADD);
    dec_check("beq",   2'b10, mk(7'h00, 3'b000, OPC_BRANCH), ALU_BEQ);
    dec_check("bne",   2'b10, mk(7'h00, 3'b001, OPC_BRANCH), ALU_BNE);
    dec_check("blt",   2'b10, mk(7'h00, 3'b100, OPC_BRANCH), ALU_BLT);
    dec_check("bge",   2'b10, mk(7'h00, 3'b101, OPC_BRANCH), ALU_BGE);
    dec_check("load",  2'b10, mk(7'h00, 3'b010, OPC_LOAD), ALU_ADD);
    dec_check("store", 2'b10, mk(7'h00, 3'b010, OPC_STORE), ALU_ADD);
    dec_check("jal",   2'b10, mk(7'h00, 3'b000, OPC_JAL), ALU_ADD);
    dec_check("jalr",  2'b10, mk(7'h00, 3'b000, OPC_JALR), ALU_ADD);
    dec_check("ecall", 2'b10, 32'h0000_0073, ALU_BEQ);
    dec_check("unk",   2'b10, mk(7'h00, 3'b000, 7'b1111111), ALU_NONE);
    dec_check("sel00", 2'b00, mk(7'h00, 3'b001, OPC_BRANCH), ALU_ADD);
    dec_check("sel01", 2'b01, mk(7'h00, 3'b000, OPC_ARITH), ALU_SUB);
    dec_check("sel11_mul", 2'b11, mk(FUNCT7_MULDIV, 3'b000, OPC_ARITH), ALU_ADD);
    check_eq("sel11_ismdu", 64'(is_mdu), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // flush during iteration 10: abort without a result
    @(posedge clk); #1;
    in_valid    = 1'b1;
    alu_op_sel  = 2'b10;
    instruction = mk(FUNCT7_MULDIV, FUNCT3_MUL, OPC_ARITH);
    rs1_data    = 32'd1234;
    rs2_data    = 32'd5678;
    repeat (10) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_stall_hold", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_stall_drop", 64'(stall), 64'd0);
    ov_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) ov_cnt++;
      @(negedge clk);
    end
    check_eq("flush_no_ov", 64'(ov_cnt), 64'd0);
    run_mdu("after_flush", FUNCT3_MUL, 32'd1234, 32'd5678);

    // flush in DONE of a divide-by-zero suppresses out_valid
    @(posedge clk); #1;
    in_valid    = 1'b1;
    instruction = mk(FUNCT7_MULDIV, FUNCT3_DIV, OPC_ARITH);
    rs1_data    = 32'd9;
    rs2_data    = 32'd0;
    @(negedge clk);
    check_eq("dflush_launch_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("dflush_ov", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("dflush_idle_stall", 64'(stall), 64'd0);
    check_eq("dflush_idle_ov", 64'(out_valid), 64'd0);

    // async reset in the middle of a divide
    run_mdu("pre_rst", FUNCT3_DIVU, 32'd1000, 32'd7);
    @(posedge clk); #1;
    in_valid    = 1'b1;
    instruction = mk(FUNCT7_MULDIV, FUNCT3_DIV, OPC_ARITH);
    rs1_data    = 32'd1000;
    rs2_data    = 32'd3;
    repeat (6) @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("mrst_stall", 64'(stall), 64'd0);
    check_eq("mrst_ov", 64'(out_valid), 64'd0);
    check_eq("mrst_res", 64'(mdu_result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // randomised M ops with edge-biased operands
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int kind;
      f3   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      case (kind)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($signed(12'($urandom))); b = 32'($signed(6'($urandom))); end
        default: ;
      endcase
      run_mdu($sformatf("rand%0d_f%0d", i, f3), f3, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Successor to the combinational ALU control unit.
- Keeps the 2-bit aluOp plus instruction decode onto 4-bit ALU codes, parametrised in XLEN.
- Adds the RV32M/RV64M multiply/divide group, executed by an iterative shift-add multiplier and a restoring divider under a small FSM.
- Sits in EX; raises a stall toward the hazard unit while a MUL/DIV instruction iterates.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- ENABLE_M, 1, 0 treats funct7=0000001 as plain arithmetic and never stalls.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  EX holds a valid instruction.
- flush  input  1  EX instruction squashed; abort any operation in flight.
- alu_op_sel  input  2  aluOp from the control unit: 00 force ADD, 01 force SUB, other values decode the instruction.
- instruction  input  32  EX instruction.
- rs1_data  input  XLEN  operand A.
- rs2_data  input  XLEN  operand B.
- alu_op  output  4  ALU code (combinational).
- is_mdu  output  1  decoded instruction is M-group (combinational).
- stall  output  1  freeze IF/ID/EX.
- out_valid  output  1  mdu_result valid for this cycle.
- mdu_result  output  XLEN  MUL/DIV result.

Behaviour:
- Reset, asynchronous: state=IDLE, count=0, out_valid=0, mdu_result=0, internal accumulators=0.
- alu_op decode, combinational:
  - Opcode/funct3 mapping and ALU code encoding are unchanged.
  - Unknown encodings give 0.
  - ECALL gives the BEQ code.
  - For M-group ops alu_op=ADD; the ALU result is ignored.
- M-group: opcode ARITHMETIC, funct7=0000001, ENABLE_M=1, alu_op_sel=10. funct3 selects:
  - 000 MUL
  - 001 MULH
  - 010 MULHSU
  - 011 MULHU
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on launch (in_valid & is_mdu & !flush):
  - Latch |A| and |B| per signedness, plus the result sign and funct3.
  - count = XLEN-1.
  - Next state is MUL or DIV.
  - Divide by zero and signed overflow (A=-2^(XLEN-1), B=-1) skip iteration and go directly to DONE.
- MUL: one bit per cycle, shift-add into a 2*XLEN product. count decrements; count=0 goes to DONE.
- DIV: one restoring step per cycle (quotient and remainder registers). count=0 goes to DONE.
- DONE:
  - out_valid=1 for exactly one cycle; mdu_result is registered.
  - Result selection:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half, sign-corrected.
    - Quotient takes the sign A^B.
    - Remainder takes the sign of A.
  - Always goes to IDLE. in_valid is ignored in DONE, so the held instruction does not relaunch.
- stall = (IDLE & launch) | MUL | DIV. It is 0 in DONE, so the pipeline advances in the same cycle that out_valid=1.
- Latency: the launch cycle plus XLEN iterate cycles gives XLEN+1 stall cycles; out_valid occurs in cycle XLEN+1 after launch.
- Special-case latency: divide-by-zero and overflow give 1 stall cycle, out_valid in the next cycle.
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = A.
- Signed overflow: quotient = A, remainder = 0.
- flush in any state: next state IDLE, stall drops in the following cycle, out_valid=0, no result is produced. flush in DONE suppresses out_valid.
- Non-M instructions: stall=0, out_valid=0; mdu_result holds its last value.
- Reset mid-operation: immediate return to IDLE and all outputs to reset values.

Decomposition:
- Shared opcodes package holds the ALU codes, opcode and funct3 constants, and adds FUNCT7_MULDIV=7'b0000001 and FUNCT3_MUL through FUNCT3_REMU.
- FSM state encoding is local.
- One natural sub-module: mdu_iter_core. It holds the shift-add/restoring datapath, count, and start/done.
- This module keeps the decode, the sign pre/post-processing, and the stall/out_valid logic.

Test Plan:
- Non-M decode: alu_op_sel=10, ADD/SUB/SLL/SRL/AND/OR/XOR/BEQ/BNE/BLT/BGE, load, store, JAL, JALR, ECALL -> expected ALU code every time; stall=0, out_valid=0.
- MUL with XLEN=32, rs1=0xFFFFFFFE (-2), rs2=3 -> stall high for 33 cycles; out_valid in cycle 33 with result 0xFFFFFFFA.
- MULH, same operands -> result 0xFFFFFFFF. MULHU -> 0x00000002.
- DIV -7/2 -> quotient 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF after 1 stall cycle. REMU 5/0 -> 5.
- Signed overflow: DIV 0x80000000/-1 -> 0x80000000. REM -> 0.
- Abort cases:
  - flush asserted at iteration 10 -> stall drops in the next cycle, out_valid never asserts; a new MUL launched afterward is correct.
  - reset mid-DIV -> state IDLE, out_valid=0, mdu_result=0.
